// File: rtl/dequant_writer_if.sv
// ---------------------------------------------------------------------------
// dequant_writer_if
// Groups the coefficient handshake from the upstream decoder and the SRAM
// write bus driven by the dequantizer.
//   coeff_valid / coeff_data / coeff_ready : quantized coefficient stream
//   SRAM_address / SRAM_write_data / SRAM_we_n : SRAM write port (we active-low)
// master : dequant_writer side (accepts coefficients, drives SRAM)
// slave  : environment side (drives coefficients, observes SRAM)
// ---------------------------------------------------------------------------
interface dequant_writer_if;
  logic        coeff_valid;
  logic [15:0] coeff_data;
  logic        coeff_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  coeff_valid,
    input  coeff_data,
    output coeff_ready,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n
  );

  modport slave (
    output coeff_valid,
    output coeff_data,
    input  coeff_ready,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n
  );
endinterface

// File: rtl/dequant_writer.sv
// ---------------------------------------------------------------------------
// dequant_writer
// Dequantizes one frame of zig-zag ordered coefficients (Y, U, V segments of
// 8x8 blocks) by a position-dependent left shift and writes them, in raster
// position, to the pre-IDCT SRAM region.
//   Clock    : system clock, rising edge
//   Resetn   : asynchronous active-low reset
//   Enable   : start pulse, honoured only in IDLE
//   Q_select : shift table select, captured with Enable
//   Done     : one-cycle pulse after the last write of the frame
//   bus      : coefficient handshake + SRAM write port (master side)
//
// state | meaning
// IDLE  | waiting for Enable
// RUN   | accepting coefficients, one SRAM write per transfer
// FLUSH | last write of the frame on the SRAM bus
// DONE  | Done pulse
// ---------------------------------------------------------------------------
module dequant_writer (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Enable,
  input  logic             Q_select,
  output logic             Done,
  dequant_writer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  // zig-zag index k -> natural index r*8+c
  localparam logic [5:0] ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [1:0]  seg_q, seg_d;
  logic        qsel_q, qsel_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_n_q, we_n_d;

  logic        ready, xfer, start;
  logic        last_col, last_row, last_coeff;
  logic [5:0]  nat;
  logic [2:0]  r, c;
  logic [3:0]  s;
  logic [2:0]  shamt;
  logic [7:0]  line;
  logic [17:0] line_w, row_off, col_off, seg_base, addr_calc;
  logic [15:0] data_calc;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Enable) state_d = S_RUN;
      S_RUN:   if (xfer && last_coeff) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = (state_q == S_RUN);
    Done  = (state_q == S_DONE);
  end

  assign xfer  = ready & bus.coeff_valid;
  assign start = (state_q == S_IDLE) & Enable;

  assign last_col   = (seg_q == 2'd0) ? (col_q == 6'd39) : (col_q == 6'd19);
  assign last_row   = (row_q == 5'd29);
  assign last_coeff = (seg_q == 2'd2) & last_row & last_col & (k_q == 6'd63);

  // ---------------- position and shift ----------------
  assign nat = ZIGZAG[k_q];
  assign r   = nat[5:3];
  assign c   = nat[2:0];
  assign s   = {1'b0, r} + {1'b0, c};

  always_comb begin
    shamt = 3'd3;
    if (!qsel_q) begin
      case (s)
        4'd0:       shamt = 3'd3;
        4'd1:       shamt = 3'd2;
        4'd2, 4'd3: shamt = 3'd3;
        4'd4, 4'd5: shamt = 3'd4;
        4'd6, 4'd7: shamt = 3'd5;
        default:    shamt = 3'd6;
      endcase
    end else begin
      case (s)
        4'd0:             shamt = 3'd3;
        4'd1, 4'd2, 4'd3: shamt = 3'd1;
        4'd4, 4'd5:       shamt = 3'd2;
        4'd6, 4'd7:       shamt = 3'd3;
        default:          shamt = 3'd4;
      endcase
    end
  end

  // Left shift of the 16-bit word; upper bits fall off (wrap, no saturation).
  assign data_calc = bus.coeff_data << shamt;

  // Line width is 320 for Y and 160 for U/V, built from two shifts each.
  assign line    = {row_q, 3'b000} + {5'd0, r};
  assign line_w  = {10'd0, line};
  assign row_off = (seg_q == 2'd0) ? ((line_w << 8) + (line_w << 6))
                                   : ((line_w << 7) + (line_w << 5));
  assign col_off = {9'd0, col_q, 3'b000} + {15'd0, c};

  always_comb begin
    case (seg_q)
      2'd0:    seg_base = 18'd76800;
      2'd1:    seg_base = 18'd153600;
      2'd2:    seg_base = 18'd192000;
      default: seg_base = 18'd0;
    endcase
  end

  assign addr_calc = seg_base + row_off + col_off;

  // ---------------- counters and write register ----------------
  always_comb begin
    k_d    = k_q;
    col_d  = col_q;
    row_d  = row_q;
    seg_d  = seg_q;
    qsel_d = qsel_q;
    if (start) begin
      k_d    = 6'd0;
      col_d  = 6'd0;
      row_d  = 5'd0;
      seg_d  = 2'd0;
      qsel_d = Q_select;
    end else if (xfer) begin
      if (k_q == 6'd63) begin
        k_d = 6'd0;
        if (last_col) begin
          col_d = 6'd0;
          if (last_row) begin
            row_d = 5'd0;
            // Steps to 3 after the final block; cleared again on the next start.
            seg_d = seg_q + 2'd1;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end else begin
        k_d = k_q + 6'd1;
      end
    end
  end

  always_comb begin
    we_n_d = ~xfer;
    addr_d = xfer ? addr_calc : addr_q;
    data_d = xfer ? data_calc : data_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      k_q    <= 6'd0;
      col_q  <= 6'd0;
      row_q  <= 5'd0;
      seg_q  <= 2'd0;
      qsel_q <= 1'b0;
      addr_q <= 18'd0;
      data_q <= 16'd0;
      we_n_q <= 1'b1;
    end else begin
      k_q    <= k_d;
      col_q  <= col_d;
      row_q  <= row_d;
      seg_q  <= seg_d;
      qsel_q <= qsel_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_n_q <= we_n_d;
    end
  end

  assign bus.coeff_ready     = ready;
  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = data_q;
  assign bus.SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_dequant_writer.sv
// ---------------------------------------------------------------------------
// tb_dequant_writer
// Directed bench for dequant_writer: streams coefficients frame by frame and
// compares selected writes against a table of hand-computed address/data.
// ---------------------------------------------------------------------------
module tb_dequant_writer;

  logic Clock = 1'b0;
  logic Resetn;
  logic Enable;
  logic Q_select;
  logic Done;

  dequant_writer_if bus_if ();

  dequant_writer dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Enable   (Enable),
    .Q_select (Q_select),
    .Done     (Done),
    .bus      (bus_if)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          qsel;
    int          idx;
    logic [15:0] din;
    logic [17:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vt [$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int find(input bit q, input int idx);
    foreach (vt[j]) if (vt[j].qsel == q && vt[j].idx == idx) return j;
    return -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we_n"},  {31'd0, bus_if.SRAM_we_n},   32'd1);
    chk({tag, "_addr"},  {14'd0, bus_if.SRAM_address}, 32'd0);
    chk({tag, "_data"},  {16'd0, bus_if.SRAM_write_data}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus_if.coeff_ready}, 32'd0);
    chk({tag, "_done"},  {31'd0, Done},               32'd0);
  endtask

  // Called at a falling edge; Q_select is flipped afterwards to prove it is held.
  task automatic start_frame(input bit q);
    Q_select = q;
    Enable   = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Enable   = 1'b0;
    Q_select = ~q;
    chk("ready_after_enable", {31'd0, bus_if.coeff_ready}, 32'd1);
  endtask

  task automatic stream(input bit q, input int last, input int stall_after);
    int j;
    for (int i = 0; i <= last; i++) begin
      j = find(q, i);
      bus_if.coeff_data  = (j >= 0) ? vt[j].din : 16'h0001;
      bus_if.coeff_valid = 1'b1;
      Enable = (i == 500);   // must be ignored while running
      @(posedge Clock);
      @(negedge Clock);
      Enable = 1'b0;
      chk($sformatf("we_n[%0d]", i), {31'd0, bus_if.SRAM_we_n}, 32'd0);
      if (j >= 0) begin
        chk($sformatf("addr[%0d]", i), {14'd0, bus_if.SRAM_address}, {14'd0, vt[j].addr});
        chk($sformatf("data[%0d]", i), {16'd0, bus_if.SRAM_write_data}, {16'd0, vt[j].data});
        if (i == stall_after) begin
          bus_if.coeff_valid = 1'b0;
          for (int n = 0; n < 5; n++) begin
            @(posedge Clock);
            @(negedge Clock);
            chk($sformatf("stall_we_n[%0d]", n), {31'd0, bus_if.SRAM_we_n}, 32'd1);
            chk($sformatf("stall_addr[%0d]", n), {14'd0, bus_if.SRAM_address}, {14'd0, vt[j].addr});
            chk($sformatf("stall_data[%0d]", n), {16'd0, bus_if.SRAM_write_data}, {16'd0, vt[j].data});
          end
        end
      end
    end
    bus_if.coeff_valid = 1'b0;
  endtask

  initial begin
    // Q1 partial frame
    vt.push_back('{1'b1, 0,    16'd5,    18'd76800,  16'd40});
    vt.push_back('{1'b1, 1,    16'hFFFD, 18'd76801,  16'hFFFA});
    vt.push_back('{1'b1, 2,    16'd7,    18'd77120,  16'd14});
    vt.push_back('{1'b1, 20,   16'd2,    18'd78400,  16'd8});
    vt.push_back('{1'b1, 63,   16'd1,    18'd79047,  16'd16});
    vt.push_back('{1'b1, 1118, 16'd1,    18'd77581,  16'd8});
    // Q0 full frame
    vt.push_back('{1'b0, 0,      16'd5,    18'd76800,  16'd40});
    vt.push_back('{1'b0, 1,      16'hFFFD, 18'd76801,  16'hFFF4});
    vt.push_back('{1'b0, 2,      16'd7,    18'd77120,  16'd28});
    vt.push_back('{1'b0, 4,      16'd3,    18'd77121,  16'd24});
    vt.push_back('{1'b0, 20,     16'd2,    18'd78400,  16'd32});
    vt.push_back('{1'b0, 63,     16'd1,    18'd79047,  16'd64});
    vt.push_back('{1'b0, 99,     16'd1,    18'd79048,  16'd32});
    vt.push_back('{1'b0, 100,    16'd1,    18'd79049,  16'd64});
    vt.push_back('{1'b0, 2496,   16'd1,    18'd77112,  16'd8});
    vt.push_back('{1'b0, 2560,   16'h3001, 18'd79360,  16'h8008});
    vt.push_back('{1'b0, 76799,  16'd1,    18'd153599, 16'd64});
    vt.push_back('{1'b0, 76800,  16'd1,    18'd153600, 16'd8});
    vt.push_back('{1'b0, 78080,  16'd1,    18'd154880, 16'd8});
    vt.push_back('{1'b0, 115200, 16'd1,    18'd192000, 16'd8});
    vt.push_back('{1'b0, 153599, 16'hFFFF, 18'd230399, 16'hFFC0});

    Resetn             = 1'b0;
    Enable             = 1'b0;
    Q_select           = 1'b0;
    bus_if.coeff_valid = 1'b0;
    bus_if.coeff_data  = 16'd0;
    repeat (2) @(negedge Clock);
    chk_reset_vals("por");
    Resetn = 1'b1;
    @(negedge Clock);
    chk("idle_ready", {31'd0, bus_if.coeff_ready}, 32'd0);

    // Q1 run up to block 17 k30, then reset mid-frame
    start_frame(1'b1);
    stream(1'b1, 1118, -1);
    Resetn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    chk("post_rst_ready", {31'd0, bus_if.coeff_ready}, 32'd0);

    // Full Q0 frame with a 5-cycle stall after coefficient 99
    start_frame(1'b0);
    stream(1'b0, 153599, 99);
    chk("flush_done",  {31'd0, Done}, 32'd0);
    chk("flush_ready", {31'd0, bus_if.coeff_ready}, 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    chk("done_pulse",  {31'd0, Done}, 32'd1);
    chk("done_we_n",   {31'd0, bus_if.SRAM_we_n}, 32'd1);
    chk("done_ready",  {31'd0, bus_if.coeff_ready}, 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    chk("done_low",    {31'd0, Done}, 32'd0);
    chk("idle_ready2", {31'd0, bus_if.coeff_ready}, 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    chk("idle_done",   {31'd0, Done}, 32'd0);
    chk("idle_ready3", {31'd0, bus_if.coeff_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
